alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH: default 32; operand/result width; legal range 8..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 rs  input  WIDTH  operand A, sampled on accept.
REQ-007 rt  input  WIDTH  operand B, sampled on accept.
REQ-008 ctrl  input  4  opcode, sampled on accept.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 rd  output  WIDTH  primary result (product low / quotient / ALU result).
REQ-012 rd_hi  output  WIDTH  product high / remainder; zero for single-cycle ops.
REQ-013 overflow  output  1  signed overflow flag for add/sub.
REQ-014 div_zero  output  1  divide-by-zero flag.

Function
REQ-015 Accept = in_valid && in_ready; operands and ctrl are registered on accept and ignored otherwise.
REQ-016 Opcodes 0000 addu, 0001 add, 0010 and, 0011 or, 0100 not rs, 0101 nor, 0110 xor, 0111 negate rs, 1000 subu, 1001 sub, 1010 sltu, 1011 slt; all modulo 2^WIDTH.
REQ-017 Opcode 1100 multu: unsigned 2*WIDTH product, {rd_hi, rd}, shift-add one bit per cycle.
REQ-018 Opcode 1101 divu: unsigned restoring division, rd = quotient, rd_hi = remainder, one bit per cycle.
REQ-019 Opcode 1110 sll: rd = rs << rt[log2(WIDTH)-1:0]; opcode 1111 srl: logical right shift, same amount field.
REQ-020 overflow = 1 only for add (operand signs equal, result sign differs) and sub (rs sign differs from rt sign, result sign differs from rs); 0 for all other opcodes.
REQ-021 slt/sltu: rd = 1 when rs < rt (signed/unsigned), else 0; upper bits zero.
REQ-022 FSM states IDLE, BUSY, DONE; IDLE->DONE on accept of single-cycle op; IDLE->BUSY on accept of 1100/1101; BUSY->DONE when iteration counter reaches WIDTH-1; DONE->IDLE on out_ready without new accept.
REQ-023 Latency: single-cycle ops out_valid the cycle after accept; multu/divu out_valid exactly WIDTH+1 cycles after accept.
REQ-024 in_ready = 1 in IDLE, or in DONE when out_ready = 1 (back-to-back: DONE->DONE or DONE->BUSY on simultaneous handoff and accept); 0 in BUSY.
REQ-025 out_valid = 1 only in DONE; rd, rd_hi, overflow, div_zero held stable while out_valid && !out_ready.
REQ-026 divu with rt = 0: rd = all ones, rd_hi = rs, div_zero = 1, still WIDTH+1 cycles latency; div_zero = 0 otherwise.
REQ-027 in_valid asserted in BUSY is not accepted and has no effect on the operation in progress.
REQ-028 Iteration counter width ceil(log2(WIDTH)); clears on every accept.

Reset
REQ-029 rst_n low forces, asynchronously: state IDLE, counter 0, out_valid 0, rd 0, rd_hi 0, overflow 0, div_zero 0; in_ready 1 one cycle after rst_n deasserts.
REQ-030 Reset during BUSY or DONE discards the operation; no result is produced after release.

Verification (WIDTH=32)
REQ-031 add 0x7FFFFFFF + 0x00000001, out_ready=1 -> next cycle out_valid, rd 0x80000000, overflow 1; addu same operands -> overflow 0.
REQ-032 slt 0xFFFFFFFF vs 0x00000001 -> rd 1; sltu same -> rd 0; sub 0x80000000 - 1 -> rd 0x7FFFFFFF, overflow 1.
REQ-033 multu 0xFFFFFFFF x 0xFFFFFFFF -> out_valid at accept+33, rd 0x00000001, rd_hi 0xFFFFFFFE; in_valid held high in BUSY not accepted.
REQ-034 divu 100 / 7 -> rd 14, rd_hi 2, div_zero 0; divu 5 / 0 -> rd 0xFFFFFFFF, rd_hi 5, div_zero 1.
REQ-035 out_ready low 5 cycles after result -> outputs stable, in_ready 0; raise out_ready with new in_valid -> handoff and accept same cycle, next result follows with no idle cycle.
REQ-036 rst_n pulsed low at accept+10 of multu -> out_valid 0 immediately, all outputs 0, no result after release.

Source files
------------

// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu -- integer ALU with an iterative multiply/divide unit.
//
// Single-cycle operations (add/sub, logic, set-less-than, shifts) produce a
// result the cycle after they are accepted. Unsigned multiply and unsigned
// divide run a one-bit-per-cycle shift-add / restoring-division loop and
// produce a result WIDTH+1 cycles after acceptance. Requests and results both
// use a valid/ready handshake, and a result may be handed off in the same
// cycle that the next request is accepted.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   request can be accepted this cycle
//   rs, rt     operands A and B (WIDTH bits), sampled on accept
//   ctrl       4-bit opcode, sampled on accept
//   out_valid  result present
//   out_ready  consumer takes the result this cycle
//   rd         ALU result / product low word / quotient
//   rd_hi      product high word / remainder; zero for single-cycle ops
//   overflow   signed overflow of add/sub
//   div_zero   divide-by-zero flag for divu
// -----------------------------------------------------------------------------
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [3:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] rd_hi,
    output logic             overflow,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int SH_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADDU  = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_NOT   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_NEG   = 4'b0111;
    localparam logic [3:0] OP_SUBU  = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_SLT   = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_SLL   = 4'b1110;
    localparam logic [3:0] OP_SRL   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] operand_b;
    logic             is_div;

    logic             accept;
    logic             is_multi;

    logic [WIDTH-1:0] alu_sum;
    logic [WIDTH-1:0] alu_diff;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;

    logic [WIDTH:0]   mul_add;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // Handshake. A new request can be taken when idle, or when the current
    // result is being consumed in the same cycle (back-to-back operation).
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign is_multi  = (ctrl == OP_MULTU) || (ctrl == OP_DIVU);

    // Single-cycle datapath, computed straight from the request so the
    // result can be captured on the accepting edge.
    always_comb begin
        alu_sum      = rs + rt;
        alu_diff     = rs - rt;
        shamt        = rt[SH_W-1:0];
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (ctrl)
            OP_ADDU: alu_result = alu_sum;
            OP_ADD: begin
                alu_result   = alu_sum;
                alu_overflow = (rs[WIDTH-1] == rt[WIDTH-1]) &&
                               (alu_sum[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_AND:  alu_result = rs & rt;
            OP_OR:   alu_result = rs | rt;
            OP_NOT:  alu_result = ~rs;
            OP_NOR:  alu_result = ~(rs | rt);
            OP_XOR:  alu_result = rs ^ rt;
            OP_NEG:  alu_result = '0 - rs;
            OP_SUBU: alu_result = alu_diff;
            OP_SUB: begin
                alu_result   = alu_diff;
                alu_overflow = (rs[WIDTH-1] != rt[WIDTH-1]) &&
                               (alu_diff[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (rs < rt)};
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
            OP_SLL:  alu_result = rs << shamt;
            OP_SRL:  alu_result = rs >> shamt;
            default: alu_result = '0;
        endcase
    end

    // One iteration of the multi-cycle loop. rd/rd_hi double as the working
    // registers: for multu {rd_hi, rd} is the partial product with the
    // multiplier shifting out of rd; for divu rd holds the dividend shifting
    // out at the top while quotient bits shift in at the bottom, and rd_hi
    // is the running remainder. A zero divisor never borrows, so the loop
    // naturally yields an all-ones quotient and a remainder equal to rs.
    always_comb begin
        mul_add   = {1'b0, rd_hi} + (rd[0] ? {1'b0, operand_b} : {(WIDTH+1){1'b0}});
        div_shift = {rd_hi, rd[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand_b};
        step_hi   = '0;
        step_lo   = '0;
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {rd[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {rd[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_add[WIDTH:1];
            step_lo = {mul_add[0], rd[WIDTH-1:1]};
        end
    end

    // Control FSM and result registers. Multi-cycle ops run WIDTH
    // iterations (count 0..WIDTH-1) in BUSY, so the result appears
    // WIDTH+1 cycles after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            rd        <= '0;
            rd_hi     <= '0;
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
            operand_b <= '0;
            is_div    <= 1'b0;
        end else if (accept) begin
            count <= '0;
            if (is_multi) begin
                state     <= BUSY;
                operand_b <= rt;
                is_div    <= (ctrl == OP_DIVU);
                rd        <= rs;
                rd_hi     <= '0;
                overflow  <= 1'b0;
                div_zero  <= (ctrl == OP_DIVU) && (rt == '0);
            end else begin
                state    <= DONE;
                rd       <= alu_result;
                rd_hi    <= '0;
                overflow <= alu_overflow;
                div_zero <= 1'b0;
            end
        end else begin
            case (state)
                BUSY: begin
                    rd    <= step_lo;
                    rd_hi <= step_hi;
                    count <= count + 1'b1;
                    if (count == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu -- directed self-checking bench for alu_mdu at WIDTH = 32.
// Inputs change on the falling edge or just after the rising edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd;
    logic [31:0] rd_hi;
    logic        overflow;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs        (rs),
        .rt        (rt),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .rd_hi     (rd_hi),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Issue one request with out_ready high and measure cycles until
    // out_valid (1 = the cycle after accept). Gives up after 100 cycles.
    task automatic issue_op(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        ctrl      = op;
        rs        = a;
        rt        = b;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rs        = '0;
        rt        = '0;
        ctrl      = '0;
        #2;
        checks++;
        if ({out_valid, overflow, div_zero, rd, rd_hi} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b ov=%b dz=%b rd=%h hi=%h, expected all zero",
                     out_valid, overflow, div_zero, rd, rd_hi);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_add_overflow();
        int lat;
        issue_op(4'b0001, 32'h7FFFFFFF, 32'h00000001, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("[TB] FAIL add_latency: got %0d, expected 1", lat);
        end
        checks++;
        if (rd !== 32'h80000000 || overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_ovf: got rd=%h ov=%b, expected rd=80000000 ov=1", rd, overflow);
        end
        issue_op(4'b0000, 32'h7FFFFFFF, 32'h00000001, lat);
        checks++;
        if (rd !== 32'h80000000 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL addu: got rd=%h ov=%b, expected rd=80000000 ov=0", rd, overflow);
        end
        issue_op(4'b0001, 32'h80000000, 32'h80000000, lat);
        checks++;
        if (rd !== 32'h00000000 || overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_negovf: got rd=%h ov=%b, expected rd=00000000 ov=1", rd, overflow);
        end
    endtask

    task automatic test_logic_ops();
        logic [3:0]  ops [6] = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
        logic [31:0] exp [6] = '{32'h00F01234, 32'hFFF0FFFF, 32'h0F0FEDCB,
                                 32'h000F0000, 32'hFF00EDCB, 32'h0F0FEDCC};
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue_op(ops[i], 32'hF0F01234, 32'h0FF0FFFF, lat);
            checks++;
            if (rd !== exp[i] || rd_hi !== 32'h0 || overflow !== 1'b0 || lat !== 1) begin
                errors++;
                $display("[TB] FAIL logic_op%b: got rd=%h hi=%h ov=%b lat=%0d, expected rd=%h hi=0 ov=0 lat=1",
                         ops[i], rd, rd_hi, overflow, lat, exp[i]);
            end
        end
    endtask

    task automatic test_slt_sub();
        logic [3:0]  ops [4] = '{4'b1011, 4'b1010, 4'b1001, 4'b1000};
        logic [31:0] a   [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000005};
        logic [31:0] b   [4] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000007};
        logic [31:0] exp [4] = '{32'h00000001, 32'h00000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
        logic        eov [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue_op(ops[i], a[i], b[i], lat);
            checks++;
            if (rd !== exp[i] || overflow !== eov[i] || rd_hi !== 32'h0) begin
                errors++;
                $display("[TB] FAIL slt_sub_op%b: got rd=%h ov=%b hi=%h, expected rd=%h ov=%b hi=0",
                         ops[i], rd, overflow, rd_hi, exp[i], eov[i]);
            end
        end
    endtask

    task automatic test_shifts();
        logic [3:0]  ops [3] = '{4'b1110, 4'b1111, 4'b1110};
        logic [31:0] a   [3] = '{32'h00000001, 32'h80000000, 32'h12345678};
        logic [31:0] b   [3] = '{32'h00000024, 32'h0000001F, 32'h00000020};
        logic [31:0] exp [3] = '{32'h00000010, 32'h00000001, 32'h12345678};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue_op(ops[i], a[i], b[i], lat);
            checks++;
            if (rd !== exp[i]) begin
                errors++;
                $display("[TB] FAIL shift%0d: got rd=%h, expected %h", i, rd, exp[i]);
            end
        end
    endtask

    task automatic test_multu();
        int lat;
        bit ready_in_busy;
        @(negedge clk);
        in_valid  = 1'b1;
        ctrl      = 4'b1100;
        rs        = 32'hFFFFFFFF;
        rt        = 32'hFFFFFFFF;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        ctrl = 4'b0000;
        rs   = 32'h00000001;
        rt   = 32'h00000002;
        ready_in_busy = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_in_busy = 1'b1;
            if (lat == 20) in_valid = 1'b0;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (ready_in_busy) begin
            errors++;
            $display("[TB] FAIL multu_busy_ready: got in_ready=1 during BUSY, expected 0");
        end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("[TB] FAIL multu_latency: got %0d, expected 33", lat);
        end
        checks++;
        if (rd !== 32'h00000001 || rd_hi !== 32'hFFFFFFFE || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL multu_result: got hi=%h lo=%h ov=%b, expected hi=FFFFFFFE lo=00000001 ov=0",
                     rd_hi, rd, overflow);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL multu_no_extra: got out_valid=%b after handoff, expected 0", out_valid);
        end
    endtask

    task automatic test_divu();
        int lat;
        issue_op(4'b1101, 32'd100, 32'd7, lat);
        checks++;
        if (lat !== 33 || rd !== 32'd14 || rd_hi !== 32'd2 || div_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL divu_100_7: got lat=%0d q=%h r=%h dz=%b, expected lat=33 q=0000000e r=00000002 dz=0",
                     lat, rd, rd_hi, div_zero);
        end
        issue_op(4'b1101, 32'd5, 32'd0, lat);
        checks++;
        if (lat !== 33 || rd !== 32'hFFFFFFFF || rd_hi !== 32'd5 || div_zero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL divu_by_zero: got lat=%0d q=%h r=%h dz=%b, expected lat=33 q=ffffffff r=00000005 dz=1",
                     lat, rd, rd_hi, div_zero);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit unstable;
        bit ready_high;
        @(negedge clk);
        in_valid  = 1'b1;
        ctrl      = 4'b0000;
        rs        = 32'd3;
        rt        = 32'd4;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        unstable   = 1'b0;
        ready_high = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || rd !== 32'd7 || rd_hi !== 32'd0 || overflow !== 1'b0) unstable = 1'b1;
            if (in_ready !== 1'b0) ready_high = 1'b1;
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("[TB] FAIL hold_stable: outputs changed while stalled, last rd=%h valid=%b, expected rd=00000007 valid=1",
                     rd, out_valid);
        end
        checks++;
        if (ready_high) begin
            errors++;
            $display("[TB] FAIL hold_in_ready: got in_ready=1 while stalled, expected 0");
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ctrl      = 4'b0110;
        rs        = 32'hFF00FF00;
        rt        = 32'h0FF00FF0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL handoff_ready: got in_ready=%b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || rd !== 32'hF0F0F0F0) begin
            errors++;
            $display("[TB] FAIL b2b_single: got valid=%b rd=%h, expected valid=1 rd=f0f0f0f0", out_valid, rd);
        end
        in_valid = 1'b1;
        ctrl     = 4'b1100;
        rs       = 32'd3;
        rt       = 32'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 33 || rd !== 32'd15 || rd_hi !== 32'd0) begin
            errors++;
            $display("[TB] FAIL b2b_multu: got lat=%0d lo=%h hi=%h, expected lat=33 lo=0000000f hi=00000000",
                     lat, rd, rd_hi);
        end
    endtask

    task automatic test_reset_busy();
        bit seen_valid;
        @(negedge clk);
        in_valid  = 1'b1;
        ctrl      = 4'b1100;
        rs        = 32'd123;
        rt        = 32'd456;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, overflow, div_zero, rd, rd_hi} !== 67'd0) begin
            errors++;
            $display("[TB] FAIL busy_reset_outputs: got valid=%b ov=%b dz=%b rd=%h hi=%h, expected all zero",
                     out_valid, overflow, div_zero, rd, rd_hi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_reset_discard: got result_seen=%b in_ready=%b, expected 0 and 1",
                     seen_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_logic_ops();
        test_slt_sub();
        test_shifts();
        test_multu();
        test_divu();
        test_back_to_back();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
